// File: rtl/alu_sequencer.sv
// alu_sequencer: latches one request, drives an external ALU for one
// cycle, then holds the captured result until downstream takes it.
module alu_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic [2:0]       in_op,
   input  logic             in_use_acc,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic [2:0]       alu_op,
   input  logic [15:0]      alu_y,
   input  logic             alu_c,
   input  logic             alu_v,
   input  logic             alu_n,
   input  logic             alu_z,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_y,
   output logic [3:0]       out_flags,
   output logic             out_err,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

   state_t      state;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [2:0]  op;
   logic [15:0] acc;
   logic        bad_op;

   assign bad_op = (op == 3'b110) || (op == 3'b111);
   assign alu_a  = op_a;
   assign alu_b  = op_b;
   assign alu_op = op;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op        <= '0;
         acc       <= '0;
         out_y     <= '0;
         out_flags <= '0;
         out_err   <= 1'b0;
         op_count  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a     <= in_use_acc ? acc : in_a;
                  op_b     <= in_b;
                  op       <= in_op;
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // Invalid op codes report an error and keep acc intact
               if (bad_op) begin
                  out_y     <= '0;
                  out_flags <= 4'b0100;
                  out_err   <= 1'b1;
               end else begin
                  out_y     <= alu_y;
                  out_flags <= {alu_n, alu_z, alu_c, alu_v};
                  out_err   <= 1'b0;
                  acc       <= alu_y;
               end
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  op_count  <= op_count + CNT_W'(1);
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU stub plus a transaction-level
// model of acc and the handshake count.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [2:0]  in_op;
   logic        in_use_acc;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_y;
   logic        alu_c;
   logic        alu_v;
   logic        alu_n;
   logic        alu_z;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;
   logic [3:0]  out_flags;
   logic        out_err;
   logic [7:0]  op_count;

   int checks = 0;
   int errors = 0;

   logic [15:0] acc_m;
   logic [7:0]  count_m;

   always #5 clk = ~clk;

   alu_sequencer #(.CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .in_use_acc (in_use_acc),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_y      (alu_y),
      .alu_c      (alu_c),
      .alu_v      (alu_v),
      .alu_n      (alu_n),
      .alu_z      (alu_z),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_y      (out_y),
      .out_flags  (out_flags),
      .out_err    (out_err),
      .op_count   (op_count)
   );

   // Returns {n,z,c,v,y}; codes 110/111 produce junk the DUT must ignore.
   function automatic logic [19:0] alu_fn(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [2:0]  o);
      logic [16:0] s;
      logic [15:0] y;
      logic        c;
      logic        v;
      c = 1'b0;
      v = 1'b0;
      case (o)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            y = s[15:0];
            c = s[16];
            v = (a[15] == b[15]) && (y[15] != a[15]);
         end
         3'b001: begin
            y = a - b;
            c = (a >= b);
            v = (a[15] != b[15]) && (y[15] != a[15]);
         end
         3'b010:  y = a & b;
         3'b011:  y = a | b;
         3'b100:  y = a ^ b;
         3'b101:  y = b;
         default: begin
            y = a ^ 16'hDEAD;
            c = 1'b1;
            v = 1'b1;
         end
      endcase
      return {y[15], (y == 16'h0000), c, v, y};
   endfunction

   always_comb begin
      {alu_n, alu_z, alu_c, alu_v, alu_y} = alu_fn(alu_a, alu_b, alu_op);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [2:0]  o,
                        input logic        use_acc,
                        input int          stall);
      logic [15:0] ea;
      logic [19:0] r;
      logic [15:0] ey;
      logic [3:0]  ef;
      logic        ee;
      ea = use_acc ? acc_m : a;
      in_valid   = 1'b1;
      in_a       = a;
      in_b       = b;
      in_op      = o;
      in_use_acc = use_acc;
      chk("idle_in_ready", in_ready, 1);
      tick();
      in_valid   = 1'b0;
      in_a       = 16'($urandom);
      in_use_acc = 1'($urandom);
      chk("exec_alu_a", alu_a, ea);
      chk("exec_alu_b", alu_b, b);
      chk("exec_alu_op", alu_op, o);
      chk("exec_out_valid", out_valid, 0);
      chk("exec_in_ready", in_ready, 0);
      r = alu_fn(ea, b, o);
      if (o == 3'b110 || o == 3'b111) begin
         ey = 16'h0000;
         ef = 4'b0100;
         ee = 1'b1;
      end else begin
         ey = r[15:0];
         ef = r[19:16];
         ee = 1'b0;
         acc_m = r[15:0];
      end
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_y", out_y, ey);
      chk("hold_out_flags", out_flags, ef);
      chk("hold_out_err", out_err, ee);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_op_count", op_count, count_m);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'($urandom);
         in_a     = 16'($urandom);
         tick();
         chk("stall_out_valid", out_valid, 1);
         chk("stall_out_y", out_y, ey);
         chk("stall_out_flags", out_flags, ef);
         chk("stall_out_err", out_err, ee);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_op_count", op_count, count_m);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      count_m   = count_m + 8'd1;
      chk("done_out_valid", out_valid, 0);
      chk("done_in_ready", in_ready, 1);
      chk("done_op_count", op_count, count_m);
   endtask

   task automatic reset_mid(input int depth);
      in_valid   = 1'b1;
      in_a       = 16'($urandom);
      in_b       = 16'($urandom);
      in_op      = 3'b000;
      in_use_acc = 1'b0;
      tick();
      in_valid = 1'b0;
      if (depth > 1) tick();
      rst       = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      rst       = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      acc_m     = 16'h0000;
      count_m   = 8'd0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_op_count", op_count, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_err", out_err, 0);
      do_op(16'($urandom), 16'h0F0F, 3'b011, 1'b1, 0);
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      in_op      = '0;
      in_use_acc = 1'b0;
      out_ready  = 1'b0;
      acc_m      = 16'h0000;
      count_m    = 8'd0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_y", out_y, 0);
      chk("reset_out_flags", out_flags, 0);
      chk("reset_out_err", out_err, 0);
      chk("reset_op_count", op_count, 0);
      chk("reset_alu_a", alu_a, 0);
      chk("reset_alu_b", alu_b, 0);
      chk("reset_alu_op", alu_op, 0);

      // Signed overflow on add
      do_op(16'h7FFF, 16'h0001, 3'b000, 1'b0, 0);
      chk("ovf_out_y", out_y, 16'h8000);
      // Zero result, then OR against the zeroed accumulator
      do_op(16'h0005, 16'h0005, 3'b001, 1'b0, 0);
      do_op(16'h1234, 16'h00FF, 3'b011, 1'b1, 0);
      // Invalid op keeps acc; the next acc use proves it
      do_op(16'hABCD, 16'h1111, 3'b110, 1'b0, 0);
      do_op(16'h5555, 16'h0000, 3'b010, 1'b1, 0);
      do_op(16'h0001, 16'h0002, 3'b111, 1'b1, 2);
      // Long downstream stall
      do_op(16'h00F0, 16'h0F00, 3'b100, 1'b0, 5);

      reset_mid(1);
      reset_mid(2);

      for (int k = 0; k < 60; k++) begin
         do_op(16'($urandom), 16'($urandom), 3'($urandom),
               1'($urandom), int'($urandom_range(0, 3)));
      end

      rst = 1'b1;
      tick();
      rst     = 1'b0;
      acc_m   = 16'h0000;
      count_m = 8'd0;
      for (int k = 0; k < 256; k++) begin
         do_op(16'($urandom), 16'($urandom), 3'($urandom),
               1'($urandom), 0);
      end
      chk("wrap_op_count", op_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
